// File: rtl/bmc_soft_pipe.sv
// Branch-metric unit for a rate-1/N Viterbi datapath: 2-entry skid, symbol stage (S1), metric stage (S2).
// Each output beat carries the distance from one received codeword to all 2^N candidates, plus frame tags.
module bmc_soft_pipe #(
  parameter int N         = 2,
  parameter int Q         = 3,
  parameter int FRAME_LEN = 64,
  parameter int MW        = $clog2(N * (2**Q - 1) + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*Q-1:0]        in_sym,
  input  logic [N-1:0]          in_erase,
  input  logic                  hard_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(2**N)*MW-1:0]  out_bm,
  output logic                  out_sof,
  output logic                  out_eof
);

  localparam int NC = 2**N;
  localparam int SW = $clog2(FRAME_LEN);
  localparam logic [Q-1:0] SMAX = '1;

  typedef struct packed {
    logic [N*Q-1:0] sym;
    logic [N-1:0]   erase;
    logic           hard;
    logic           sof;
    logic           eof;
  } beat_t;

  // Handshake: a beat moves on any edge where valid & ready are both high; a held
  // valid keeps its payload stable until ready; in_ready depends only on registered state.
  beat_t          in_beat;
  beat_t          s1_beat;
  beat_t          skid [2];
  logic [1:0]     skid_cnt;
  logic           skid_rd;
  logic           skid_wr;
  logic           s1_valid;
  logic [SW-1:0]  step;
  logic           mode_q;
  logic           accept;
  logic           s2_en;
  logic           s1_en;
  logic           pop;
  logic           load_direct;
  logic           push;
  logic [NC*MW-1:0] bm_next;

  assign in_ready    = (skid_cnt != 2'd2);
  assign accept      = in_valid & in_ready;
  assign s2_en       = !out_valid | out_ready;
  assign s1_en       = !s1_valid | s2_en;
  assign pop         = s1_en & (skid_cnt != 2'd0);
  assign load_direct = s1_en & (skid_cnt == 2'd0) & accept;
  assign push        = accept & !load_direct;

  // Tags and mode are bound to the beat at acceptance so they travel with the data.
  always_comb begin
    in_beat.sym   = in_sym;
    in_beat.erase = in_erase;
    in_beat.sof   = (step == '0);
    in_beat.eof   = (step == SW'(FRAME_LEN - 1));
    in_beat.hard  = (step == '0) ? hard_mode : mode_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step   <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      step <= in_beat.eof ? '0 : step + SW'(1);
      if (in_beat.sof) mode_q <= hard_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (push) skid[skid_wr] <= in_beat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_cnt <= 2'd0;
      skid_rd  <= 1'b0;
      skid_wr  <= 1'b0;
    end else begin
      if (push) skid_wr <= ~skid_wr;
      if (pop)  skid_rd <= ~skid_rd;
      case ({push, pop})
        2'b10:   skid_cnt <= skid_cnt + 2'd1;
        2'b01:   skid_cnt <= skid_cnt - 2'd1;
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

  // Skid entries are older than the incoming beat, so they always feed S1 first.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_beat  <= '0;
    end else if (s1_en) begin
      s1_valid <= pop | load_direct;
      if (pop)              s1_beat <= skid[skid_rd];
      else if (load_direct) s1_beat <= in_beat;
    end
  end

  always_comb begin
    logic [MW-1:0] acc;
    logic [MW-1:0] d;
    logic [Q-1:0]  s;
    logic          e;
    bm_next = '0;
    acc     = '0;
    d       = '0;
    s       = '0;
    e       = 1'b0;
    for (int c = 0; c < NC; c++) begin
      acc = '0;
      for (int i = 0; i < N; i++) begin
        s = s1_beat.sym[i*Q +: Q];
        e = c[i];
        if (s1_beat.erase[i])  d = '0;
        else if (s1_beat.hard) d = MW'(s[Q-1] ^ e);
        else if (e)            d = MW'(SMAX - s);
        else                   d = MW'(s);
        acc = acc + d;
      end
      bm_next[c*MW +: MW] = acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_bm    <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_bm  <= bm_next;
        out_sof <= s1_beat.sof;
        out_eof <= s1_beat.eof;
      end
    end
  end

endmodule
